// File: rtl/fft_out_reorder_if.sv
// Handshake bundle for fft_out_reorder: bit-reversed sample stream in, natural-order stream out.
interface fft_out_reorder_if #(
  parameter int DW    = 24,
  parameter int LOG2N = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    din_r;
  logic signed [DW-1:0]    din_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    dout_r;
  logic signed [DW-1:0]    dout_i;
  logic [LOG2N-1:0]        out_index;
  logic                    out_last;

  modport slave (
    input  in_valid, din_r, din_i, out_ready,
    output in_ready, out_valid, dout_r, dout_i, out_index, out_last
  );

  modport master (
    output in_valid, din_r, din_i, out_ready,
    input  in_ready, out_valid, dout_r, dout_i, out_index, out_last
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output, reads frames back in natural order.
// Output register loads one cycle after a bank fills; producer stalls only while both banks are full.
module fft_out_reorder #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int DW    = 24
) (
  input logic              clk,
  input logic              rst_n,
  fft_out_reorder_if.slave bus
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] raddr;
  logic             wbank;
  logic             rbank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic [2*DW-1:0]  mem [2][N];

  logic wr_en, wr_last, rd_en, rd_last;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  // full[] gates both sides, so the write and read banks can never coincide.
  assign bus.in_ready = ~full[wbank];
  assign wr_en        = bus.in_valid & ~full[wbank];
  assign wr_last      = wr_en & (wcnt == LAST);
  assign rd_en        = full[rbank] & (~bus.out_valid | bus.out_ready);
  assign rd_last      = rd_en & (raddr == LAST);

  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wbank] = 1'b1;
    if (rd_last) full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wbank][bitrev(wcnt)] <= {bus.din_r, bus.din_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt          <= '0;
      raddr         <= '0;
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      full          <= '0;
      bus.out_valid <= 1'b0;
      bus.dout_r    <= '0;
      bus.dout_i    <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        wcnt <= wcnt + LOG2N'(1);
        if (wr_last) wbank <= ~wbank;
      end
      if (rd_en) begin
        {bus.dout_r, bus.dout_i} <= mem[rbank][raddr];
        bus.out_index <= raddr;
        bus.out_last  <= (raddr == LAST);
        bus.out_valid <= 1'b1;
        raddr         <= raddr + LOG2N'(1);
        if (rd_last) rbank <= ~rbank;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: queue-based frame model of the bit-reversal permutation, one negedge monitor.
module tb_fft_out_reorder;
  localparam int N = 64, LOG2N = 6, DW = 24;

  typedef struct packed {
    logic [DW-1:0]    r;
    logic [DW-1:0]    i;
    logic [LOG2N-1:0] idx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.DW(DW), .LOG2N(LOG2N)) bus ();
  fft_out_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, fails = 0;
  exp_t expq[$];
  logic [2*DW-1:0] cur[N];
  int wpos = 0, n_acc = 0, n_out = 0, ready_pct = 100, last_cnt = 0;
  bit prev_stall = 1'b0;
  logic signed [DW-1:0] hold_r, hold_i;
  logic [LOG2N-1:0] hold_idx;
  logic hold_last;
  logic signed [DW-1:0] seen_r[N], seen_i[N];
  bit stream_mode = 1'b0, stream_started = 1'b0, sender_done = 1'b0;
  int stream_outs = 0, stream_gaps = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ref_bitrev(input int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int rnd24();
    int sel = $urandom_range(9);
    if (sel == 0) return -8388608;
    if (sel == 1) return 8388607;
    return $signed($urandom) >>> 8;
  endfunction

  // Monitor: records accepted inputs into the model and checks every output transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_r", bus.dout_r, hold_r);
        chk("hold_i", bus.dout_i, hold_i);
        chk("hold_index", bus.out_index, hold_idx);
        chk("hold_last", bus.out_last, hold_last);
      end
      if (stream_mode) begin
        if (bus.out_valid) stream_started = 1'b1;
        if (stream_started && stream_outs < 4 * N) begin
          if (!bus.out_valid) stream_gaps++;
          if (bus.out_valid && bus.out_ready) stream_outs++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("out_r", bus.dout_r, $signed(e.r));
          chk("out_i", bus.dout_i, $signed(e.i));
          chk("out_index", bus.out_index, e.idx);
          chk("out_last", bus.out_last, (e.idx == N - 1) ? 1 : 0);
          seen_r[bus.out_index] = bus.dout_r;
          seen_i[bus.out_index] = bus.dout_i;
          if (bus.out_last) last_cnt++;
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      hold_r = bus.dout_r; hold_i = bus.dout_i;
      hold_idx = bus.out_index; hold_last = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        cur[wpos] = {bus.din_r, bus.din_i};
        wpos++;
        n_acc++;
        if (wpos == N) begin
          for (int n = 0; n < N; n++) begin
            e.r   = cur[ref_bitrev(n)][2*DW-1:DW];
            e.i   = cur[ref_bitrev(n)][DW-1:0];
            e.idx = LOG2N'(n);
            expq.push_back(e);
          end
          wpos = 0;
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic send(input int r, input int i, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.din_r = r[DW-1:0];
    bus.din_i = i[DW-1:0];
    @(negedge clk);
    while (!bus.in_ready && waits < 5000) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 5000) chk("send_timeout", waits, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while (expq.size() != 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(nm, expq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, stalls, base, c;
    bus.in_valid = 1'b0;
    bus.din_r = '0;
    bus.din_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dout_r", bus.dout_r, 0);
    chk("rst_dout_i", bus.dout_i, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_out_last", bus.out_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Single frame with ramp data
    ready_pct = 100;
    last_cnt = 0;
    for (int k = 0; k < N; k++) send(k, -k, w);
    chk("t1_valid_at_accept", bus.out_valid, 0);
    @(posedge clk); #2;
    chk("t1_valid_rise", bus.out_valid, 1);
    chk("t1_first_index", bus.out_index, 0);
    wait_drain("t1_drain");
    chk("t1_n1_r", seen_r[1], 32);
    chk("t1_n2_r", seen_r[2], 16);
    chk("t1_n63_r", seen_r[63], 63);
    chk("t1_n1_i", seen_i[1], -32);
    chk("t1_last_count", last_cnt, 1);

    // Continuous streaming of 4 frames
    stream_mode = 1'b1;
    stalls = 0;
    for (int k = 0; k < 4 * N; k++) begin
      send(rnd24(), rnd24(), w);
      stalls += w;
    end
    wait_drain("t2_drain");
    stream_mode = 1'b0;
    chk("t2_in_ready_stalls", stalls, 0);
    chk("t2_outputs", stream_outs, 4 * N);
    chk("t2_valid_gaps", stream_gaps, 0);

    // Backpressure with three frames offered
    ready_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    base = n_acc;
    sender_done = 1'b0;
    fork
      begin
        int ws;
        for (int f = 0; f < 3; f++)
          for (int k = 0; k < N; k++) send(1000 * (f + 1) + k, -(1000 * (f + 1) + k), ws);
        sender_done = 1'b1;
      end
    join_none
    c = 0;
    while (n_acc < base + 2 * N && c < 2000) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #2;
    chk("t3_in_ready_low", bus.in_ready, 0);
    chk("t3_valid", bus.out_valid, 1);
    chk("t3_head_r", bus.dout_r, 1000);
    chk("t3_head_index", bus.out_index, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_still_head", bus.dout_r, 1000);
    chk("t3_accepted", n_acc - base, 2 * N);
    ready_pct = 100;
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
    end while (!bus.in_ready && c < 500);
    chk("t3_ready_return_index", bus.out_index, N - 1);
    chk("t3_ready_return_valid", bus.out_valid, 1);
    c = 0;
    while (!sender_done && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("t3_sender_done", sender_done, 1);
    wait_drain("t3_drain");

    // Random gaps and stalls
    ready_pct = 30;
    base = n_out;
    for (int k = 0; k < 10 * N; k++) begin
      while ($urandom_range(1) == 0) begin
        @(posedge clk); #1;
      end
      send(rnd24(), rnd24(), w);
    end
    wait_drain("t4_drain");
    chk("t4_outputs", n_out - base, 10 * N);

    // Reset mid-frame
    ready_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) send(5000 + k, -5000 - k, w);
    for (int k = 0; k < 8; k++) send(6000 + k, 6000 + k, w);
    ready_pct = 100;
    for (int k = 8; k < 40; k++) send(6000 + k, 6000 + k, w);
    chk("t5_frame0_pending", (expq.size() > 0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_dout_r", bus.dout_r, 0);
    chk("t5_rst_dout_i", bus.dout_i, 0);
    chk("t5_rst_last", bus.out_last, 0);
    chk("t5_rst_in_ready", bus.in_ready, 1);
    expq.delete();
    wpos = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = n_out;
    for (int k = 0; k < N; k++) send(rnd24(), rnd24(), w);
    wait_drain("t5_drain");
    repeat (150) @(posedge clk);
    #1;
    chk("t5_output_count", n_out - base, N);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output-side counterpart of the FFT delay-line pipeline. The last butterfly stage emits complex samples in bit-reversed order; this block accepts that stream and re-emits each frame in natural frequency order.
- Uses a ping-pong pair of N-word complex buffers so one frame is written while the previous frame is read.
- Sits between the final FFT stage and the downstream consumer (demapper / bus interface).
- Valid/ready handshake on both sides.

Parameters:
- N, 64, FFT size in samples per frame; must be a power of two, 8..1024.
- LOG2N, 6, log2(N); index width.
- DW, 24, width of each real/imag component, signed two's complement.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept a sample this cycle.
- din_r  input  DW  input real part, signed, bit-reversed order.
- din_i  input  DW  input imaginary part, signed.
- out_valid  output  1  dout_* / out_index hold a valid sample.
- out_ready  input  1  consumer accepts the output sample.
- dout_r  output  DW  output real part, natural order.
- dout_i  output  DW  output imaginary part.
- out_index  output  LOG2N  natural-order bin index of the current output (0..N-1).
- out_last  output  1  high with out_valid when out_index == N-1.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset clears everything and takes effect immediately mid-frame; partially written or partially read frames are discarded.
  - Write counter wcnt=0, wbank=0, rbank=0, raddr=0, full[1:0]=0.
  - Outputs: out_valid=0, dout_r=0, dout_i=0, out_index=0, out_last=0; in_ready=1 one cycle after release.
- Storage: two banks, each N entries of 2*DW bits. Registers or inferred RAM, with a registered read.
- Write side:
  - in_ready = ~full[wbank].
  - A sample is accepted when in_valid & in_ready. It is written to bank wbank at address bitrev(wcnt), i.e. wcnt with its LOG2N bits reversed. wcnt then increments modulo N.
  - On accepting the sample with wcnt==N-1: set full[wbank], toggle wbank, wcnt wraps to 0.
  - No data is ever dropped; the producer stalls while in_ready=0.
- Read side:
  - The read engine is active when full[rbank]=1.
  - Output register load condition: full[rbank] & (~out_valid | out_ready).
  - On load: dout <= bank[rbank][raddr], out_index <= raddr, out_last <= (raddr==N-1), out_valid <= 1, raddr increments.
  - On loading raddr==N-1: clear full[rbank], toggle rbank, raddr wraps to 0. The freed bank is writable (in_ready may rise) on the next cycle.
  - If out_valid & out_ready and there is no load: out_valid <= 0.
  - If out_valid & ~out_ready: dout, out_index and out_last hold stable.
- Latency: first output (index 0) is valid on the cycle after the edge that accepted the frame's Nth sample.
  - With out_ready held 1, a frame streams out in N consecutive cycles with no bubbles.
  - Continuous input at 1 sample/cycle is sustained indefinitely; in_ready never drops.
- Simultaneous events:
  - A write completing bank A and a read finishing bank B on the same edge are both honoured.
  - The read engine moves directly to the next full bank with no idle cycle.
  - Write and read never target the same bank in the same cycle, because full[] gates both.
- Both banks full and out_ready=0: in_ready=0, outputs hold, no state changes.
- No arithmetic on data: samples pass bit-exact, with sign preserved.

Test Plan:
- Single frame, natural check: N=64, feed din_r=k, din_i=-k for k=0..63 back-to-back, out_ready=1 -> out_valid rises one cycle after sample 63 accepted. Output n has din_r=bitrev6(n) (n=1->32, n=2->16, n=63->63) and din_i = its negation. out_last only at n=63.
- Continuous streaming: 4 frames, in_valid=1 every cycle, out_ready=1 -> in_ready never 0, out_valid continuous from first output with 256 outputs total, each frame's data correct and in order.
- Backpressure: out_ready=0 throughout 3 frames of input -> in_ready falls after the 128th sample accepted. dout holds frame0 index 0 with out_valid=1 stable. Releasing out_ready drains all 128 samples in order, and in_ready returns 1 the cycle after frame0 index 63 is loaded.
- Random stalls: random in_valid (50%) and out_ready (30%) over 10 frames with random signed 24-bit data (including -8388608 and 8388607) -> scoreboard matches bit-reversed permutation exactly, with no loss or duplication.
- Reset mid-frame: assert rst_n=0 after 40 samples of frame1 while frame0 is half read out -> out_valid=0, dout=0 immediately. After release, a fresh frame is reordered correctly and no stale frame0/frame1 data appears.
